// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversamples sclk/cs/mosi on clk, shifts MSB first,
// with a one-entry transmit holding register and a single-byte receive port.
module spi_slave #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] in_data,
    input  logic             wr,
    output logic             tx_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             rx_valid,
    input  logic             rd,
    output logic             overrun,
    output logic             busy
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e state_q, state_d;

    logic sclk_s1, sclk_s2, sclk_s3;
    logic cs_s1, cs_s2, cs_s3;
    logic mosi_s1, mosi_s2;

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             miso_q, miso_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             rx_valid_q, rx_valid_d;
    logic             overrun_q, overrun_d;
    logic             tx_load;

    // Synchroniser flops reset to 0 so a held-low cs is not seen as a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            {sclk_s1, sclk_s2, sclk_s3} <= '0;
            {cs_s1, cs_s2, cs_s3}       <= '0;
            {mosi_s1, mosi_s2}          <= '0;
        end else begin
            {sclk_s1, sclk_s2, sclk_s3} <= {sclk, sclk_s1, sclk_s2};
            {cs_s1, cs_s2, cs_s3}       <= {cs, cs_s1, cs_s2};
            {mosi_s1, mosi_s2}          <= {mosi, mosi_s1};
        end
    end

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;
    assign cs_rise   = cs_s2 & ~cs_s3;
    assign cs_fall   = ~cs_s2 & cs_s3;

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cs_fall) state_d = StShift;
            StShift: if (cs_rise) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StShift);
    end

    always_comb begin
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        miso_d      = miso_q;
        out_d       = out_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        tx_load     = 1'b0;

        if (rd) rx_valid_d = 1'b0;

        if (state_q == StIdle) begin
            if (cs_fall) begin
                cnt_d   = '0;
                tx_load = 1'b1;
            end
        end else if (cs_rise) begin
            cnt_d  = '0;
            miso_d = 1'b0;
        end else if (sclk_rise) begin
            rx_d = {rx_q[WIDTH-2:0], mosi_s2};
            if (cnt_q == CntLast) begin
                // Completion overrides a same-cycle rd.
                out_d      = rx_d;
                rx_valid_d = 1'b1;
                if (rx_valid_q && !rd) overrun_d = 1'b1;
                cnt_d      = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else if (sclk_fall) begin
            if (cnt_q != '0) begin
                tx_d   = tx_q << 1;
                miso_d = tx_q[WIDTH-2];
            end else begin
                tx_load = 1'b1;
            end
        end

        if (tx_load) begin
            tx_d        = hold_full_q ? hold_q : '0;
            hold_full_d = 1'b0;
            miso_d      = tx_d[WIDTH-1];
        end

        if (wr && !hold_full_q) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            out_q       <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
            out_q       <= out_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign miso     = miso_q;
    assign tx_ready = ~hold_full_q;
    assign out_data = out_q;
    assign rx_valid = rx_valid_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a task-based mode-0 master with sclk = clk/8,
// checking miso bits, received bytes and port flags against hand-computed values.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] in_data = '0;
    logic       wr = 1'b0;
    logic       tx_ready;
    logic [7:0] out_data;
    logic       rx_valid;
    logic       rd = 1'b0;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    spi_slave #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .in_data  (in_data),
        .wr       (wr),
        .tx_ready (tx_ready),
        .out_data (out_data),
        .rx_valid (rx_valid),
        .rd       (rd),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        tick(4);
    endtask

    task automatic cs_high();
        cs = 1'b1;
        tick(6);
    endtask

    task automatic write_tx(input logic [7:0] v);
        in_data = v;
        wr = 1'b1;
        tick(1);
        wr = 1'b0;
    endtask

    task automatic read_ack();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
        tick(1);
    endtask

    // Mode-0 master: drive mosi while sclk low, sample miso just before each rise.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            tick(4);
            got[7-i] = miso;
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
        tick(4);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".miso"},     32'(miso),     32'h0);
        check({tag, ".tx_ready"}, 32'(tx_ready), 32'h1);
        check({tag, ".out_data"}, 32'(out_data), 32'h0);
        check({tag, ".rx_valid"}, 32'(rx_valid), 32'h0);
        check({tag, ".overrun"},  32'(overrun),  32'h0);
        check({tag, ".busy"},     32'(busy),     32'h0);
    endtask

    initial begin
        logic [7:0] got;

        tick(3);
        rst = 1'b0;
        tick(1);
        check_reset_outputs("reset");

        // Basic exchange
        write_tx(8'hAA);
        check("basic.tx_ready_after_wr", 32'(tx_ready), 32'h0);
        cs_low();
        check("basic.tx_ready_after_cs", 32'(tx_ready), 32'h1);
        check("basic.busy", 32'(busy), 32'h1);
        xfer(8'h91, 8, got);
        check("basic.miso_byte", 32'(got), 32'hAA);
        check("basic.out_data", 32'(out_data), 32'h91);
        check("basic.rx_valid", 32'(rx_valid), 32'h1);
        cs_high();
        check("basic.miso_idle", 32'(miso), 32'h0);
        check("basic.busy_idle", 32'(busy), 32'h0);
        read_ack();
        check("basic.rx_valid_rd", 32'(rx_valid), 32'h0);

        // Back-to-back under one cs low
        write_tx(8'hF0);
        cs_low();
        check("b2b.tx_ready", 32'(tx_ready), 32'h1);
        write_tx(8'h12);
        xfer(8'h3C, 8, got);
        check("b2b.miso0", 32'(got), 32'hF0);
        check("b2b.out0", 32'(out_data), 32'h3C);
        check("b2b.valid0", 32'(rx_valid), 32'h1);
        check("b2b.tx_ready_reload", 32'(tx_ready), 32'h1);
        read_ack();
        check("b2b.valid_rd", 32'(rx_valid), 32'h0);
        xfer(8'hC3, 8, got);
        check("b2b.miso1", 32'(got), 32'h12);
        check("b2b.out1", 32'(out_data), 32'hC3);
        check("b2b.valid1", 32'(rx_valid), 32'h1);
        check("b2b.overrun", 32'(overrun), 32'h0);
        cs_high();
        read_ack();

        // Overrun: two frames without rd
        cs_low();
        xfer(8'h55, 8, got);
        check("ovr.overrun_first", 32'(overrun), 32'h0);
        xfer(8'h66, 8, got);
        cs_high();
        check("ovr.out_data", 32'(out_data), 32'h66);
        check("ovr.overrun", 32'(overrun), 32'h1);
        check("ovr.rx_valid", 32'(rx_valid), 32'h1);
        read_ack();
        check("ovr.rx_valid_rd", 32'(rx_valid), 32'h0);
        check("ovr.overrun_sticky", 32'(overrun), 32'h1);

        // Underrun: nothing written
        cs_low();
        xfer(8'h3A, 8, got);
        check("udr.miso_zero", 32'(got), 32'h00);
        check("udr.out_data", 32'(out_data), 32'h3A);
        cs_high();
        read_ack();

        // Abort after 3 bits
        write_tx(8'hFF);
        cs_low();
        xfer(8'h5A, 3, got);
        check("abort.miso_bits", 32'(got), 32'hE0);
        check("abort.miso_mid", 32'(miso), 32'h1);
        cs_high();
        check("abort.rx_valid", 32'(rx_valid), 32'h0);
        check("abort.miso", 32'(miso), 32'h0);
        check("abort.out_kept", 32'(out_data), 32'h3A);
        cs_low();
        xfer(8'hA5, 8, got);
        check("abort.lost_byte", 32'(got), 32'h00);
        check("abort.next_out", 32'(out_data), 32'hA5);
        check("abort.next_valid", 32'(rx_valid), 32'h1);
        cs_high();

        // Reset mid-frame, with a byte held and rx_valid/overrun set
        cs_low();
        write_tx(8'h77);
        check("rstmid.tx_ready_held", 32'(tx_ready), 32'h0);
        xfer(8'hFF, 5, got);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_reset_outputs("rstmid");
        tick(6);
        check("rstmid.busy_cs_low", 32'(busy), 32'h0);
        check("rstmid.rx_valid_later", 32'(rx_valid), 32'h0);
        cs_high();
        cs_low();
        check("rstmid.busy_new", 32'(busy), 32'h1);
        xfer(8'h81, 8, got);
        check("rstmid.miso_zero", 32'(got), 32'h00);
        check("rstmid.out_data", 32'(out_data), 32'h81);
        check("rstmid.rx_valid", 32'(rx_valid), 32'h1);
        check("rstmid.overrun", 32'(overrun), 32'h0);
        cs_high();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI mode-0 slave (CPOL=0, CPHA=0, MSB first) that forms the far end of the link driven by `spi_master`. It oversamples `sclk`, `cs` and `mosi` with the system clock, deserialises received bytes to a parallel read port, and serialises bytes from a one-entry transmit holding register onto `miso`. The block is used as a loopback/peripheral model and as the slave side in system builds.

## Interface
- `WIDTH`, 8: bits per SPI frame and width of the parallel data ports.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sclk`  in  1  SPI clock from the master; asynchronous to `clk`.
- `cs`  in  1  active-low chip select from the master; asynchronous.
- `mosi`  in  1  serial data from the master; asynchronous.
- `miso`  out  1  serial data to the master.
- `in_data`  in  WIDTH  byte to transmit; captured when `wr`=1 and `tx_ready`=1.
- `wr`  in  1  write strobe for the transmit holding register.
- `tx_ready`  out  1  holding register empty; `wr` is accepted.
- `out_data`  out  WIDTH  last received byte.
- `rx_valid`  out  1  `out_data` holds an unread byte; cleared by `rd`.
- `rd`  in  1  read acknowledge; clears `rx_valid`.
- `overrun`  out  1  sticky: a byte completed while `rx_valid`=1. Cleared only by `rst`.
- `busy`  out  1  `cs` (synchronised) is low.

## Operation
- Synchronisers: `sclk`, `cs` and `mosi` each pass through 2 flops (s1, s2). `sclk` and `cs` also feed a third flop (s3) for edge detection. A rise is s2=1 and s3=0; a fall is s2=0 and s3=1.
- States are IDLE (cs_s2=1) and SHIFT (cs_s2=0).
- IDLE → SHIFT on a `cs` fall:
  - bit counter ← 0;
  - tx shifter ← holding register if it is full, otherwise all-zeros (underrun);
  - holding register marked empty;
  - `miso` ← MSB of the new tx shifter.
- On an `sclk` rise in SHIFT:
  - rx shifter ← {rx[WIDTH-2:0], mosi_s2};
  - counter increments.
  - When the counter reaches WIDTH: `out_data` ← assembled byte; `rx_valid` ← 1; `overrun` ← 1 if `rx_valid` was already 1 and `rd` is not asserted in that same cycle; counter ← 0.
- On an `sclk` fall in SHIFT:
  - If counter≠0: the tx shifter shifts left and `miso` takes the next bit.
  - If counter=0 (frame boundary, `cs` still low): the tx shifter reloads from the holding register (or all-zeros), the holding register is marked empty, and `miso` takes the new MSB.
- SHIFT → IDLE on a `cs` rise:
  - A partial frame is discarded: no `rx_valid`, counter ← 0.
  - `miso` ← 0.
  - A byte already moved into the tx shifter is lost. The holding register is unchanged.
- Transmit port:
  - `wr` with `tx_ready`=1 loads `in_data` and drops `tx_ready` on the next cycle.
  - `wr` with `tx_ready`=0 is ignored.
  - `tx_ready` returns to 1 the cycle after the shifter consumes the byte.
- Receive port:
  - `rd` clears `rx_valid` on the next cycle.
  - If a completion and `rd` fall in the same cycle, the completion wins: `rx_valid` stays 1 and `out_data` takes the new byte.
- Reset values: `miso`=0, `tx_ready`=1, `out_data`=0, `rx_valid`=0, `overrun`=0, `busy`=0. The state is IDLE, all shifters, counters and synchroniser flops are cleared, and the holding register is empty.
- Reset mid-frame aborts immediately with the same values. Pin activity resumes being interpreted only after `cs` is seen high, then falls again.

## Timing
- Edge-detect latency is 3 `clk` cycles from a pin transition to the action cycle. Actions register at the end of that cycle.
- `rx_valid` rises 3 `clk` cycles after the WIDTH-th `sclk` rise at the pins; `miso` updates 3 cycles after an `sclk` fall.
- Requirement on the master: `sclk` high and low phases each ≥ 4 `clk` periods, and the `cs` fall → first `sclk` rise gap ≥ 4 `clk` periods. This gives `miso` ≥ 1 `clk` of setup before the master samples.
- `busy` follows cs_s2 inverted, registered: it rises 3 cycles after the `cs` fall.
- Single-cycle strobes are sufficient for `wr` and `rd`.

## Test plan
- Basic exchange: `wr` with `in_data`=0xAA, then the master sends 0x91 with `sclk`=clk/8 → `miso` bits 1,0,1,0,1,0,1,0; `out_data`=0x91; `rx_valid`=1; `tx_ready`=1 after the `cs` fall.
- Back-to-back: load 0xF0, and load 0x12 once `tx_ready` rises; the master sends 0x3C then 0xC3 under one `cs` low → `miso` carries 0xF0 then 0x12; `rx_valid` each frame with `rd` in between; `overrun`=0.
- Overrun: two frames (0x55, 0x66) with no `rd` → `out_data`=0x66, `overrun`=1, `rx_valid`=1. A following `rd` clears `rx_valid` but not `overrun`.
- Underrun: no `wr` before the `cs` fall → `miso` sends 0x00; the received byte is still captured correctly.
- Abort: `cs` rises after 3 `sclk` rises → no `rx_valid`, `miso`=0. The next full frame sending 0xA5 yields `out_data`=0xA5.
- Reset mid-frame: assert `rst` for 1 cycle after 5 bits → all outputs return to their reset values. A subsequent frame (new `cs` fall) receives 0x81 correctly.
